port_endpoint: RTL and testbench
================================

// Module: port_endpoint
// PURPOSE
//  Peripheral-side responder for one CPU I/O port (the word pair seen on port_d_out/port_d_in plus
//  the per-port inform_write/inform_read strobes). CPU port writes push into a TX FIFO drained by a
//  valid/ready device stream; a device RX stream fills an RX FIFO that the CPU reads and pops.
//  Word 0 is data, word 1 is control (CPU->dev) / status (dev->CPU). One instance per used port.
// PARAMETERS
//  FIFO_DEPTH  8   entries per FIFO; power of two, 2..16
//  DATA_WIDTH  16  port word width; fixed at 16 in this design
// PORTS
//  clk          in   1   system clock, all state on rising edge
//  rst_n        in   1   synchronous reset, active low
//  cpu_wdata    in   16x2 CPU port output pair: [0] TX data, [1] control word
//  cpu_inform_write in 1 one-cycle strobe: CPU wrote this port this cycle
//  cpu_inform_read  in 1 one-cycle strobe: CPU consumed cpu_rdata[0] this cycle
//  cpu_rdata    out  16x2 CPU port input pair: [0] RX head data, [1] status word
//  tx_valid     out  1   TX FIFO non-empty
//  tx_data      out  16  TX FIFO head
//  tx_ready     in   1   device accepts tx_data when tx_valid && tx_ready
//  rx_valid     in   1   device offers rx_data
//  rx_data      in   16  device data
//  rx_ready     out  1   = !rx_full; transfer on rx_valid && rx_ready
// BEHAVIOUR
//  Reset (rst_n=0 at edge): both FIFOs empty, pointers/counts 0, flags 0; cpu_rdata[0]=0,
//   cpu_rdata[1]=status of empty state (rx_empty=1, all else 0), tx_valid=0, rx_ready=1.
//   Reset mid-transfer discards all buffered data; no partial handshake survives.
//  Write: on cpu_inform_write, if cpu_wdata[1][15]=0 -> push cpu_wdata[0] to TX;
//   if cpu_wdata[1][15]=1 -> control op, no push: bit0 = clear sticky flags.
//  Push lands at edge; tx_valid/tx_data/status reflect it next cycle (1-cycle latency).
//  TX full push: dropped, FIFO unchanged, tx_overflow set. Exception: if device pops in the same
//   cycle (tx_valid&&tx_ready) the push succeeds; count unchanged.
//  Read: cpu_rdata[0] is registered FWFT head of RX (0 when empty); CPU samples it in the cycle it
//   raises cpu_inform_read; pop takes effect at that edge, next head visible the following cycle.
//   Read when empty: no pointer change, rx_underflow set.
//  RX: rx_valid&&rx_ready at edge N -> data at cpu_rdata[0] (if was empty) from N+1.
//   Simultaneous RX push and CPU pop on full RX: rx_ready=0 so no push; pop only.
//  Pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits, never exceeds DEPTH.
//  Status word (registered): [4:0] rx_count, [9:5] tx_count, [10] rx_empty, [11] tx_full,
//   [12] tx_overflow, [13] rx_underflow, [15:14] 0. Counts zero-extended to 5 bits.
//  Clear op and a new error event in the same cycle: event wins (flag stays 1).
// CONFIGURATION
//  PORT_ENDPOINT_STICKY_EN defined: bits [13:12] are sticky error flags, cleared only by reset
//   or the control op. Not defined: no flag registers, bits [13:12] read 0, overflow/underflow
//   still drop/ignore silently, control op bit0 ignored.
// STRUCTURE
//  Package port_pkg: STATUS_* bit-index localparams, CTRL_OP_BIT=15, CTRL_CLR_BIT=0,
//   typedef port_word_t = logic [15:0].
//  Sub-module port_fifo (sync FIFO: push/pop/full/empty/count, registered head), instanced twice.
// TESTING
//  1 Reset: hold rst_n=0 2 cycles -> cpu_rdata[1]=16'h0400, tx_valid=0, rx_ready=1.
//  2 CPU writes 16'hBEEF (ctrl 0), tx_ready=0 -> next cycle tx_valid=1, tx_data=BEEF, tx_count=1;
//    raise tx_ready -> tx_valid=0 next cycle.
//  3 Fill TX with 8 writes, 9th write 16'h1234 -> dropped, tx_full=1, tx_overflow=1 (STICKY_EN);
//    write ctrl 16'h8001 -> tx_overflow=0; repeat 9th write with tx_ready=1 -> accepted.
//  4 Device sends 16'h0011,16'h0022 -> rx_count=2, rdata[0]=0011; inform_read -> next cycle 0022;
//    second read -> rx_empty=1, rdata[0]=0; third read -> rx_underflow=1, counts unchanged.
//  5 Fill RX to 8 -> rx_ready=0; rx_valid held with 16'h00FF -> not taken until one pop, then taken.
//  6 Assert rst_n=0 with both FIFOs half full -> next cycle matches scenario 1 state exactly.

Source files
------------

// File: rtl/port_pkg.sv
// Shared definitions for the port endpoint: word type, status/control bit
// positions and the status word packer.
package port_pkg;

   typedef logic [15:0] port_word_t;

   localparam int unsigned STATUS_RX_CNT_LSB = 0;
   localparam int unsigned STATUS_TX_CNT_LSB = 5;
   localparam int unsigned STATUS_RX_EMPTY   = 10;
   localparam int unsigned STATUS_TX_FULL    = 11;
   localparam int unsigned STATUS_TX_OVF     = 12;
   localparam int unsigned STATUS_RX_UNF     = 13;

   localparam int unsigned CTRL_OP_BIT  = 15;
   localparam int unsigned CTRL_CLR_BIT = 0;

   function automatic port_word_t pack_status(
      input logic [4:0] rx_count,
      input logic [4:0] tx_count,
      input logic       rx_empty,
      input logic       tx_full,
      input logic       tx_ovf,
      input logic       rx_unf
   );
      port_word_t s;
      s = '0;
      s[STATUS_RX_CNT_LSB +: 5] = rx_count;
      s[STATUS_TX_CNT_LSB +: 5] = tx_count;
      s[STATUS_RX_EMPTY]        = rx_empty;
      s[STATUS_TX_FULL]         = tx_full;
      s[STATUS_TX_OVF]          = tx_ovf;
      s[STATUS_RX_UNF]          = rx_unf;
      return s;
   endfunction

endpackage

// File: rtl/port_endpoint_if.sv
// CPU port pair plus device TX/RX streams seen by one port endpoint.
// master: CPU/device side driving the endpoint; slave: the endpoint itself.
interface port_endpoint_if;
   import port_pkg::*;

   port_word_t [1:0] cpu_wdata;
   logic             cpu_inform_write;
   logic             cpu_inform_read;
   port_word_t [1:0] cpu_rdata;
   logic             tx_valid;
   port_word_t       tx_data;
   logic             tx_ready;
   logic             rx_valid;
   port_word_t       rx_data;
   logic             rx_ready;

   modport master (
      output cpu_wdata, cpu_inform_write, cpu_inform_read, tx_ready, rx_valid, rx_data,
      input  cpu_rdata, tx_valid, tx_data, rx_ready
   );

   modport slave (
      input  cpu_wdata, cpu_inform_write, cpu_inform_read, tx_ready, rx_valid, rx_data,
      output cpu_rdata, tx_valid, tx_data, rx_ready
   );

endinterface

// File: rtl/port_fifo.sv
// Synchronous FIFO with a registered first-word-fall-through head (0 when empty).
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module port_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           data_i,
   input  logic                       pop_i,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic [WIDTH-1:0]           head_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic             push_ok, pop_ok;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = head_q;

   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full_o || pop_ok);

   // Next pointers, count and head; the head is recomputed from the post-edge state
   // so a push into an empty FIFO is visible the cycle after it lands.
   always_comb begin
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      head_d  = '0;
      if (push_ok) wr_d = wr_q + AW'(1);
      if (pop_ok)  rd_d = rd_q + AW'(1);
      if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
      else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
      if (count_d != '0) begin
         if (push_ok && (wr_q == rd_d)) head_d = data_i;
         else                           head_d = mem_q[rd_d];
      end
   end

   // Pointer, count and head state.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         head_q  <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
         head_q  <= head_d;
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_q] <= data_i;
   end

endmodule

// File: rtl/port_endpoint.sv
// Peripheral-side responder for one CPU I/O port: CPU writes feed a TX FIFO
// drained by the device stream; the device RX stream fills an RX FIFO the CPU
// reads. Optional feature macro: PORT_ENDPOINT_STICKY_EN (sticky error flags).
module port_endpoint
   import port_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   port_endpoint_if.slave bus
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   logic          ctrl_op, data_wr, clr_req;
   logic          tx_full, tx_empty, tx_pop;
   logic          rx_full, rx_empty;
   logic [CW-1:0] tx_count, rx_count;
   port_word_t    tx_head, rx_head;
   logic          tx_ovf_evt, rx_unf_evt;
   logic          tx_ovf, rx_unf;

   assign ctrl_op = bus.cpu_inform_write && bus.cpu_wdata[1][CTRL_OP_BIT];
   assign data_wr = bus.cpu_inform_write && !bus.cpu_wdata[1][CTRL_OP_BIT];
   assign clr_req = ctrl_op && bus.cpu_wdata[1][CTRL_CLR_BIT];

   assign tx_pop     = bus.tx_ready && !tx_empty;
   assign tx_ovf_evt = data_wr && tx_full && !tx_pop;
   assign rx_unf_evt = bus.cpu_inform_read && rx_empty;

   port_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_WIDTH)) u_tx_fifo (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .push_i  (data_wr),
      .data_i  (bus.cpu_wdata[0]),
      .pop_i   (bus.tx_ready),
      .full_o  (tx_full),
      .empty_o (tx_empty),
      .count_o (tx_count),
      .head_o  (tx_head)
   );

   port_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_WIDTH)) u_rx_fifo (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .push_i  (bus.rx_valid && !rx_full),
      .data_i  (bus.rx_data),
      .pop_i   (bus.cpu_inform_read),
      .full_o  (rx_full),
      .empty_o (rx_empty),
      .count_o (rx_count),
      .head_o  (rx_head)
   );

`ifdef PORT_ENDPOINT_STICKY_EN
   logic tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d;
   logic ctrl_unused;

   // Sticky flag update: clear first, so an event in the same cycle wins.
   always_comb begin
      tx_ovf_d = tx_ovf_q;
      rx_unf_d = rx_unf_q;
      if (clr_req) begin
         tx_ovf_d = 1'b0;
         rx_unf_d = 1'b0;
      end
      if (tx_ovf_evt) tx_ovf_d = 1'b1;
      if (rx_unf_evt) rx_unf_d = 1'b1;
   end

   // Sticky flag registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx_ovf_q <= 1'b0;
         rx_unf_q <= 1'b0;
      end else begin
         tx_ovf_q <= tx_ovf_d;
         rx_unf_q <= rx_unf_d;
      end
   end

   assign tx_ovf      = tx_ovf_q;
   assign rx_unf      = rx_unf_q;
   assign ctrl_unused = ^bus.cpu_wdata[1][14:1];
`else
   logic ctrl_unused;

   assign tx_ovf      = 1'b0;
   assign rx_unf      = 1'b0;
   assign ctrl_unused = ^{bus.cpu_wdata[1][14:0], clr_req, tx_ovf_evt, rx_unf_evt};
`endif

   assign bus.tx_valid     = !tx_empty;
   assign bus.tx_data      = tx_head;
   assign bus.rx_ready     = !rx_full;
   assign bus.cpu_rdata[0] = rx_head;
   assign bus.cpu_rdata[1] = pack_status(5'(rx_count), 5'(tx_count), rx_empty, tx_full,
                                         tx_ovf, rx_unf);

endmodule

// File: tb/tb_port_endpoint.sv
// Directed self-checking bench for port_endpoint (FIFO_DEPTH=8).
// Expectations for bits [13:12] follow PORT_ENDPOINT_STICKY_EN.
module tb_port_endpoint;

`ifdef PORT_ENDPOINT_STICKY_EN
   localparam logic [15:0] OVF = 16'h1000;
   localparam logic [15:0] UNF = 16'h2000;
`else
   localparam logic [15:0] OVF = 16'h0000;
   localparam logic [15:0] UNF = 16'h0000;
`endif

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   port_endpoint_if bus ();

   port_endpoint #(.FIFO_DEPTH(8), .DATA_WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired: got=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.cpu_wdata        = '0;
      bus.cpu_inform_write = 1'b0;
      bus.cpu_inform_read  = 1'b0;
      bus.tx_ready         = 1'b0;
      bus.rx_valid         = 1'b0;
      bus.rx_data          = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      checks++;
      if (bus.cpu_rdata[1] !== 16'h0400) begin
         errors++; $display("FAIL reset_status got=%h required=%h", bus.cpu_rdata[1], 16'h0400);
      end
      checks++;
      if (bus.cpu_rdata[0] !== 16'h0000) begin
         errors++; $display("FAIL reset_rdata got=%h required=0000", bus.cpu_rdata[0]);
      end
      checks++;
      if (bus.tx_valid !== 1'b0) begin
         errors++; $display("FAIL reset_tx_valid got=%b required=0", bus.tx_valid);
      end
      checks++;
      if (bus.rx_ready !== 1'b1) begin
         errors++; $display("FAIL reset_rx_ready got=%b required=1", bus.rx_ready);
      end
   endtask

   task automatic test_tx_single();
      bus.cpu_wdata[0] = 16'hBEEF;
      bus.cpu_wdata[1] = 16'h0000;
      bus.cpu_inform_write = 1'b1;
      step();
      bus.cpu_inform_write = 1'b0;
      checks++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 16'hBEEF) begin
         errors++; $display("FAIL tx_single_head got=%b/%h required=1/beef", bus.tx_valid, bus.tx_data);
      end
      checks++;
      if (bus.cpu_rdata[1] !== 16'h0420) begin
         errors++; $display("FAIL tx_single_status got=%h required=0420", bus.cpu_rdata[1]);
      end
      bus.tx_ready = 1'b1;
      step();
      bus.tx_ready = 1'b0;
      checks++;
      if (bus.tx_valid !== 1'b0 || bus.cpu_rdata[1] !== 16'h0400) begin
         errors++; $display("FAIL tx_single_drain got=%b/%h required=0/0400", bus.tx_valid, bus.cpu_rdata[1]);
      end
   endtask

   task automatic test_tx_overflow();
      logic [15:0] exp;
      bus.cpu_wdata[1] = 16'h0000;
      bus.cpu_inform_write = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.cpu_wdata[0] = 16'h1000 + 16'(i);
         step();
      end
      bus.cpu_inform_write = 1'b0;
      checks++;
      if (bus.cpu_rdata[1] !== 16'h0D00 || bus.tx_data !== 16'h1000) begin
         errors++; $display("FAIL tx_fill got=%h/%h required=0d00/1000", bus.cpu_rdata[1], bus.tx_data);
      end
      bus.cpu_wdata[0] = 16'h1234;
      bus.cpu_inform_write = 1'b1;
      step();
      bus.cpu_inform_write = 1'b0;
      exp = 16'h0D00 | OVF;
      checks++;
      if (bus.cpu_rdata[1] !== exp || bus.tx_data !== 16'h1000) begin
         errors++; $display("FAIL tx_overflow got=%h/%h required=%h/1000", bus.cpu_rdata[1], bus.tx_data, exp);
      end
      bus.cpu_wdata[1] = 16'h8001;
      bus.cpu_inform_write = 1'b1;
      step();
      bus.cpu_inform_write = 1'b0;
      checks++;
      if (bus.cpu_rdata[1] !== 16'h0D00) begin
         errors++; $display("FAIL tx_clear got=%h required=0d00", bus.cpu_rdata[1]);
      end
      bus.cpu_wdata[0] = 16'h1234;
      bus.cpu_wdata[1] = 16'h0000;
      bus.cpu_inform_write = 1'b1;
      bus.tx_ready = 1'b1;
      step();
      bus.cpu_inform_write = 1'b0;
      bus.tx_ready = 1'b0;
      checks++;
      if (bus.cpu_rdata[1] !== 16'h0D00 || bus.tx_data !== 16'h1001) begin
         errors++; $display("FAIL tx_full_push_pop got=%h/%h required=0d00/1001", bus.cpu_rdata[1], bus.tx_data);
      end
      bus.tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         exp = (i < 7) ? 16'h1001 + 16'(i) : 16'h1234;
         checks++;
         if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp) begin
            errors++; $display("FAIL tx_drain[%0d] got=%b/%h required=1/%h", i, bus.tx_valid, bus.tx_data, exp);
         end
         step();
      end
      bus.tx_ready = 1'b0;
      checks++;
      if (bus.tx_valid !== 1'b0 || bus.cpu_rdata[1] !== 16'h0400) begin
         errors++; $display("FAIL tx_empty_after got=%b/%h required=0/0400", bus.tx_valid, bus.cpu_rdata[1]);
      end
   endtask

   task automatic test_rx_read();
      logic [15:0] exp;
      bus.rx_valid = 1'b1;
      bus.rx_data  = 16'h0011;
      step();
      bus.rx_data  = 16'h0022;
      step();
      bus.rx_valid = 1'b0;
      checks++;
      if (bus.cpu_rdata[1] !== 16'h0002 || bus.cpu_rdata[0] !== 16'h0011) begin
         errors++; $display("FAIL rx_two got=%h/%h required=0002/0011", bus.cpu_rdata[1], bus.cpu_rdata[0]);
      end
      bus.cpu_inform_read = 1'b1;
      step();
      bus.cpu_inform_read = 1'b0;
      checks++;
      if (bus.cpu_rdata[1] !== 16'h0001 || bus.cpu_rdata[0] !== 16'h0022) begin
         errors++; $display("FAIL rx_read1 got=%h/%h required=0001/0022", bus.cpu_rdata[1], bus.cpu_rdata[0]);
      end
      bus.cpu_inform_read = 1'b1;
      step();
      checks++;
      if (bus.cpu_rdata[1] !== 16'h0400 || bus.cpu_rdata[0] !== 16'h0000) begin
         errors++; $display("FAIL rx_read2 got=%h/%h required=0400/0000", bus.cpu_rdata[1], bus.cpu_rdata[0]);
      end
      step();
      bus.cpu_inform_read = 1'b0;
      exp = 16'h0400 | UNF;
      checks++;
      if (bus.cpu_rdata[1] !== exp || bus.cpu_rdata[0] !== 16'h0000) begin
         errors++; $display("FAIL rx_underflow got=%h/%h required=%h/0000", bus.cpu_rdata[1], bus.cpu_rdata[0], exp);
      end
      bus.cpu_inform_read = 1'b1;
      bus.cpu_wdata[1] = 16'h8001;
      bus.cpu_inform_write = 1'b1;
      step();
      bus.cpu_inform_read = 1'b0;
      checks++;
      if (bus.cpu_rdata[1] !== exp) begin
         errors++; $display("FAIL rx_clear_vs_event got=%h required=%h", bus.cpu_rdata[1], exp);
      end
      step();
      bus.cpu_inform_write = 1'b0;
      bus.cpu_wdata[1] = 16'h0000;
      checks++;
      if (bus.cpu_rdata[1] !== 16'h0400) begin
         errors++; $display("FAIL rx_clear got=%h required=0400", bus.cpu_rdata[1]);
      end
   endtask

   task automatic test_rx_full();
      logic [15:0] exp;
      bus.rx_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.rx_data = 16'h00A0 + 16'(i);
         step();
      end
      bus.rx_data = 16'h00FF;
      checks++;
      if (bus.rx_ready !== 1'b0 || bus.cpu_rdata[1] !== 16'h0008 || bus.cpu_rdata[0] !== 16'h00A0) begin
         errors++; $display("FAIL rx_fill got=%b/%h/%h required=0/0008/00a0", bus.rx_ready, bus.cpu_rdata[1], bus.cpu_rdata[0]);
      end
      step();
      step();
      checks++;
      if (bus.cpu_rdata[1] !== 16'h0008 || bus.cpu_rdata[0] !== 16'h00A0) begin
         errors++; $display("FAIL rx_full_hold got=%h/%h required=0008/00a0", bus.cpu_rdata[1], bus.cpu_rdata[0]);
      end
      bus.cpu_inform_read = 1'b1;
      step();
      bus.cpu_inform_read = 1'b0;
      checks++;
      if (bus.rx_ready !== 1'b1 || bus.cpu_rdata[1] !== 16'h0007 || bus.cpu_rdata[0] !== 16'h00A1) begin
         errors++; $display("FAIL rx_full_pop got=%b/%h/%h required=1/0007/00a1", bus.rx_ready, bus.cpu_rdata[1], bus.cpu_rdata[0]);
      end
      step();
      bus.rx_valid = 1'b0;
      checks++;
      if (bus.rx_ready !== 1'b0 || bus.cpu_rdata[1] !== 16'h0008) begin
         errors++; $display("FAIL rx_refill got=%b/%h required=0/0008", bus.rx_ready, bus.cpu_rdata[1]);
      end
      bus.cpu_inform_read = 1'b1;
      for (int i = 0; i < 8; i++) begin
         exp = (i < 7) ? 16'h00A1 + 16'(i) : 16'h00FF;
         checks++;
         if (bus.cpu_rdata[0] !== exp) begin
            errors++; $display("FAIL rx_drain[%0d] got=%h required=%h", i, bus.cpu_rdata[0], exp);
         end
         step();
      end
      bus.cpu_inform_read = 1'b0;
      checks++;
      if (bus.cpu_rdata[1] !== 16'h0400) begin
         errors++; $display("FAIL rx_empty_after got=%h required=0400", bus.cpu_rdata[1]);
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] exp;
      bus.cpu_inform_read = 1'b1;
      step();
      bus.cpu_inform_read = 1'b0;
      bus.cpu_wdata[1] = 16'h0000;
      bus.cpu_inform_write = 1'b1;
      bus.rx_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.cpu_wdata[0] = 16'h5500 + 16'(i);
         bus.rx_data      = 16'h6600 + 16'(i);
         step();
      end
      exp = 16'h0084 | UNF;
      checks++;
      if (bus.cpu_rdata[1] !== exp || bus.cpu_rdata[0] !== 16'h6600 || bus.tx_data !== 16'h5500) begin
         errors++; $display("FAIL half_full got=%h/%h/%h required=%h/6600/5500", bus.cpu_rdata[1], bus.cpu_rdata[0], bus.tx_data, exp);
      end
      rst_n = 1'b0;
      bus.tx_ready = 1'b1;
      bus.cpu_inform_read = 1'b1;
      step();
      rst_n = 1'b1;
      idle_inputs();
      checks++;
      if (bus.cpu_rdata[1] !== 16'h0400 || bus.cpu_rdata[0] !== 16'h0000) begin
         errors++; $display("FAIL mid_reset_cpu got=%h/%h required=0400/0000", bus.cpu_rdata[1], bus.cpu_rdata[0]);
      end
      checks++;
      if (bus.tx_valid !== 1'b0 || bus.rx_ready !== 1'b1) begin
         errors++; $display("FAIL mid_reset_dev got=%b/%b required=0/1", bus.tx_valid, bus.rx_ready);
      end
      step();
      checks++;
      if (bus.cpu_rdata[1] !== 16'h0400 || bus.tx_valid !== 1'b0) begin
         errors++; $display("FAIL post_reset_idle got=%h/%b required=0400/0", bus.cpu_rdata[1], bus.tx_valid);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      idle_inputs();
      test_reset();
      test_tx_single();
      test_tx_overflow();
      test_rx_read();
      test_rx_full();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
